// File: rtl/sr_input_conditioner.sv
// Turns two raw pushbuttons into clean, mutually exclusive Set/Reset pulses for
// a downstream SR latch: synchronise, debounce, edge-detect, then arbitrate.
module sr_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_WIDTH     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_set,
   input  logic btn_reset,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int PCW  = $clog2(PULSE_WIDTH) + 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PCW-1:0] PCNT_LOAD = PCW'(PULSE_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SET_PULSE,
      RESET_PULSE
   } state_t;

   // Channel index 0 = set, 1 = reset
   logic [1:0]         meta_q, sync_q;
   logic [1:0]         deb_q, deb_d, deb_prev_q;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic [1:0]         press;

   state_t             state_q;
   logic [PCW-1:0]     pcnt_q;
   logic               s_q, r_q, conflict_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {btn_reset, btn_set};
         sync_q <= meta_q;
      end
   end

   // Any sample matching the current level restarts the stability count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         if (sync_q[ch] != deb_q[ch]) begin
            if (cnt_q[ch] == CNT_LAST) deb_d[ch] = sync_q[ch];
            else                       cnt_d[ch] = cnt_q[ch] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_q      <= '0;
         deb_prev_q <= '0;
         cnt_q      <= '0;
      end else begin
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
      end
   end

   assign press = deb_q & ~deb_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pcnt_q     <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (press[0] && press[1]) begin
                  conflict_q <= 1'b1;
               end else if (press[0]) begin
                  state_q <= SET_PULSE;
                  s_q     <= 1'b1;
                  pcnt_q  <= PCNT_LOAD;
               end else if (press[1]) begin
                  state_q <= RESET_PULSE;
                  r_q     <= 1'b1;
                  pcnt_q  <= PCNT_LOAD;
               end
            end
            SET_PULSE: begin
               if (press[1]) conflict_q <= 1'b1;
               if (pcnt_q == '0) begin
                  state_q <= IDLE;
                  s_q     <= 1'b0;
               end else begin
                  pcnt_q <= pcnt_q - PCW'(1);
               end
            end
            RESET_PULSE: begin
               if (press[0]) conflict_q <= 1'b1;
               if (pcnt_q == '0) begin
                  state_q <= IDLE;
                  r_q     <= 1'b0;
               end else begin
                  pcnt_q <= pcnt_q - PCW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               s_q     <= 1'b0;
               r_q     <= 1'b0;
            end
         endcase
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign busy     = s_q | r_q;
   assign conflict = conflict_q;

endmodule
